// File: rtl/serdes_rx_ctrl.sv
// Serial receive controller: finds a 32-bit sync marker, tracks frame slots,
// and hands data words to a consumer through a 2-entry output FIFO.
module serdes_rx_ctrl #(
  parameter logic [31:0] SYNC_WORD   = 32'hA5A5_5A5A,
  parameter int unsigned SYNC_PERIOD = 16,
  parameter int unsigned MISS_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        enable,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        locked,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned SLOT_W = $clog2(SYNC_PERIOD);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SYNC_PERIOD - 1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [3:0]        MISS_MAX  = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [31:0]        sr_r;
  logic [4:0]         bit_cnt_r;
  logic [SLOT_W-1:0]  slot_cnt_r;
  logic [3:0]         miss_cnt_r;
  logic               pend_valid_r;
  logic [31:0]        pend_data_r;
  logic [31:0]        tail_data_r;
  logic               tail_valid_r;

  logic               sync_hit_s;
  logic               word_end_s;
  logic               sync_slot_s;
  logic               lose_s;
  logic               pop_s;
  logic               drop_s;
  logic [31:0]        head_data_next_s;
  logic               head_valid_next_s;
  logic [31:0]        tail_data_next_s;
  logic               tail_valid_next_s;

  // word_end_s marks the cycle in which sr_r holds all 32 bits of a framed word
  assign sync_hit_s  = (sr_r == SYNC_WORD);
  assign word_end_s  = enable && (state_r == LOCKED) && (bit_cnt_r == 5'd31);
  assign sync_slot_s = (slot_cnt_r == SLOT_ZERO);
  assign lose_s      = word_end_s && sync_slot_s && !sync_hit_s &&
                       ((miss_cnt_r + 4'd1) == MISS_MAX);
  assign pop_s       = out_valid && out_ready;

  // Next-state logic: enable low overrides every state
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = HUNT;
        HUNT:    state_next_s = sync_hit_s ? LOCKED : HUNT;
        LOCKED:  state_next_s = lose_s ? HUNT : LOCKED;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register with lock indicator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      locked  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      locked  <= (state_next_s == LOCKED);
    end
  end

  // LSB-first deserialiser, frozen while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r <= 32'h0000_0000;
    end else if (state_r != IDLE) begin
      sr_r <= {din, sr_r[31:1]};
    end
  end

  // Bit, slot and missed-marker counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r  <= 5'd0;
      slot_cnt_r <= SLOT_ZERO;
      miss_cnt_r <= 4'd0;
    end else if (!enable) begin
      bit_cnt_r  <= 5'd0;
      slot_cnt_r <= SLOT_ZERO;
      miss_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        HUNT: begin
          bit_cnt_r  <= 5'd0;
          slot_cnt_r <= sync_hit_s ? SLOT_ONE : SLOT_ZERO;
          miss_cnt_r <= 4'd0;
        end
        LOCKED: begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
          if (word_end_s) begin
            slot_cnt_r <= (slot_cnt_r == SLOT_LAST) ? SLOT_ZERO : (slot_cnt_r + SLOT_ONE);
            if (sync_slot_s) begin
              miss_cnt_r <= sync_hit_s ? 4'd0 : (miss_cnt_r + 4'd1);
            end
          end
        end
        default: begin
          bit_cnt_r  <= 5'd0;
          slot_cnt_r <= SLOT_ZERO;
          miss_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Capture stage: latches each completed data word before it enters the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_data_r  <= 32'h0000_0000;
    end else begin
      pend_valid_r <= word_end_s && !sync_slot_s;
      if (word_end_s) begin
        pend_data_r <= sr_r;
      end
    end
  end

  // FIFO update: pop first, then the push lands in the first free entry
  always_comb begin
    head_data_next_s  = out_data;
    head_valid_next_s = out_valid;
    tail_data_next_s  = tail_data_r;
    tail_valid_next_s = tail_valid_r;
    drop_s            = 1'b0;
    if (pop_s) begin
      head_data_next_s  = tail_data_r;
      head_valid_next_s = tail_valid_r;
      tail_valid_next_s = 1'b0;
    end else begin
      head_valid_next_s = out_valid;
    end
    if (pend_valid_r) begin
      if (!head_valid_next_s) begin
        head_data_next_s  = pend_data_r;
        head_valid_next_s = 1'b1;
      end else if (!tail_valid_next_s) begin
        tail_data_next_s  = pend_data_r;
        tail_valid_next_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // FIFO head doubles as the registered output port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data     <= 32'h0000_0000;
      out_valid    <= 1'b0;
      tail_data_r  <= 32'h0000_0000;
      tail_valid_r <= 1'b0;
    end else begin
      out_data     <= head_data_next_s;
      out_valid    <= head_valid_next_s;
      tail_data_r  <= tail_data_next_s;
      tail_valid_r <= tail_valid_next_s;
    end
  end

  // Drop reporting with saturating counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      overflow <= drop_s;
      if (drop_s && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_serdes_rx_ctrl.sv
// Directed bench for serdes_rx_ctrl: acquisition, frame tracking, lock loss,
// back-pressure, full-FIFO push/pop and asynchronous reset mid-word.
module tb_serdes_rx_ctrl;

  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        enable;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        locked;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  int ovf_seen = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  serdes_rx_ctrl #(
    .SYNC_WORD  (SYNC),
    .SYNC_PERIOD(4),
    .MISS_LIMIT (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .enable   (enable),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .locked   (locked),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // Record accepted words and overflow pulses mid-cycle
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (overflow) ovf_seen <= ovf_seen + 1;
  end

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic start_lock();
    enable = 1'b1;
    send_zeros(40);
    send_word(SYNC);
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; out_ready = 1'b0; din = 1'b0;
    #1;
    vectors++;
    if ({out_data, out_valid, locked, overflow, drop_cnt} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h valid=%b locked=%b ovf=%b drops=%0d, expected all 0",
               out_data, out_valid, locked, overflow, drop_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send_word(SYNC);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignores_sync: locked=%b expected 0", locked);
    end
    enable = 1'b1;
    send_zeros(8);
    vectors++;
    if (locked !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_no_lock: locked=%b valid=%b expected 0 0", locked, out_valid);
    end
  endtask

  task automatic test_acquire();
    logic [31:0] exp [3];
    logic [31:0] w;
    int base;
    exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'd3;
    do_reset();
    out_ready = 1'b1;
    base = got.size();
    start_lock();
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL acq_lock_early: locked=%b expected 0 at marker end", locked);
    end
    w = exp[0];
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i]);
      if (i == 0) begin
        vectors++;
        if (locked !== 1'b1) begin
          miscompares++;
          $display("FAIL acq_lock_rise: locked=%b expected 1", locked);
        end
      end
    end
    w = exp[1];
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i]);
      if (i == 0) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL acq_valid_early: valid=%b expected 0 one edge after last bit", out_valid);
        end
      end
      if (i == 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp[0]) begin
          miscompares++;
          $display("FAIL acq_valid_latency: valid=%b data=%h expected 1 %h", out_valid, out_data, exp[0]);
        end
      end
    end
    send_word(exp[2]);
    send_zeros(3);
    vectors++;
    if (got.size() - base !== 3) begin
      miscompares++;
      $display("FAIL acq_count: got %0d words expected 3", got.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got.size() <= base + i || got[base + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL acq_data[%0d]: got %h expected %h", i,
                 (got.size() > base + i) ? got[base + i] : 32'h0, exp[i]);
      end
    end
  endtask

  task automatic test_frame_tracking();
    logic [31:0] stream [7];
    logic [31:0] exp [6];
    int base;
    stream = '{32'h0000_00A1, SYNC, 32'h0000_00C3, SYNC, 32'h0000_00D4, 32'hFFFF_FFFF, 32'h8000_0001};
    exp    = '{32'h0000_00A1, SYNC, 32'h0000_00C3, 32'h0000_00D4, 32'hFFFF_FFFF, 32'h8000_0001};
    do_reset();
    out_ready = 1'b1;
    base = got.size();
    start_lock();
    for (int k = 0; k < 7; k++) begin
      send_word(stream[k]);
      vectors++;
      if (locked !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_locked[%0d]: locked=%b expected 1", k, locked);
      end
    end
    send_zeros(3);
    vectors++;
    if (got.size() - base !== 6) begin
      miscompares++;
      $display("FAIL frame_count: got %0d words expected 6", got.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got.size() <= base + i || got[base + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL frame_data[%0d]: got %h expected %h", i,
                 (got.size() > base + i) ? got[base + i] : 32'h0, exp[i]);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [31:0] exp [11];
    int base;
    exp = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99,
            32'h0BAD_F00D, 32'h1234_5678};
    do_reset();
    out_ready = 1'b1;
    base = got.size();
    start_lock();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 3; k++) send_word(exp[f * 3 + k]);
      send_word(32'h0000_0000);
      if (f < 2) begin
        vectors++;
        if (locked !== 1'b1) begin
          miscompares++;
          $display("FAIL loss_early[%0d]: locked=%b expected 1", f, locked);
        end
      end
    end
    send_bit(1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_fall: locked=%b expected 0 after third bad marker", locked);
    end
    send_zeros(40);
    send_word(SYNC);
    send_word(exp[9]);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_relock: locked=%b expected 1", locked);
    end
    send_word(exp[10]);
    send_zeros(3);
    vectors++;
    if (got.size() - base !== 11) begin
      miscompares++;
      $display("FAIL loss_count: got %0d words expected 11", got.size() - base);
    end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (got.size() <= base + i || got[base + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL loss_data[%0d]: got %h expected %h", i,
                 (got.size() > base + i) ? got[base + i] : 32'h0, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int ovf_base;
    do_reset();
    base = got.size();
    ovf_base = ovf_seen;
    start_lock();
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    send_word(32'hCAFE_0003);
    send_word(SYNC);
    send_word(32'hCAFE_0004);
    send_zeros(3);
    vectors++;
    if (ovf_seen - ovf_base !== 2) begin
      miscompares++;
      $display("FAIL bp_overflow_pulses: got %0d expected 2", ovf_seen - ovf_base);
    end
    vectors++;
    if (drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL bp_drop_cnt: got %0d expected 2", drop_cnt);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b data=%h expected 1 cafe0001", out_valid, out_data);
    end
    out_ready = 1'b1;
    send_zeros(4);
    vectors++;
    if (got.size() - base !== 2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words expected 2", got.size() - base);
    end
    vectors++;
    if (got.size() < base + 2 || got[base] !== 32'hCAFE_0001 || got[base + 1] !== 32'hCAFE_0002) begin
      miscompares++;
      $display("FAIL bp_data: got %h %h expected cafe0001 cafe0002",
               (got.size() > base) ? got[base] : 32'h0,
               (got.size() > base + 1) ? got[base + 1] : 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    logic [31:0] w;
    int base;
    int ovf_base;
    exp = '{32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 32'hBEEF_0004};
    do_reset();
    base = got.size();
    ovf_base = ovf_seen;
    start_lock();
    send_word(exp[0]);
    send_word(exp[1]);
    send_word(exp[2]);
    w = SYNC;
    for (int i = 0; i < 32; i++) begin
      if (i == 1) out_ready = 1'b1;
      send_bit(w[i]);
      if (i == 1) begin
        vectors++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== exp[1]) begin
          miscompares++;
          $display("FAIL b2b_push_pop: ovf=%b valid=%b data=%h expected 0 1 %h",
                   overflow, out_valid, out_data, exp[1]);
        end
      end
    end
    send_word(exp[3]);
    send_zeros(3);
    vectors++;
    if (ovf_seen - ovf_base !== 0 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_no_drop: pulses=%0d drops=%0d expected 0 0", ovf_seen - ovf_base, drop_cnt);
    end
    vectors++;
    if (got.size() - base !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words expected 4", got.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got.size() <= base + i || got[base + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h expected %h", i,
                 (got.size() > base + i) ? got[base + i] : 32'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int base;
    do_reset();
    start_lock();
    send_word(32'h0000_0077);
    send_word(32'h0000_0088);
    send_word(32'h0000_0099);
    for (int i = 0; i < 17; i++) send_bit(SYNC[i]);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0077 || drop_cnt !== 8'd1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_before: valid=%b data=%h drops=%0d locked=%b expected 1 00000077 1 1",
               out_valid, out_data, drop_cnt, locked);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_data, out_valid, locked, overflow, drop_cnt} !== 43'd0) begin
      miscompares++;
      $display("FAIL rmw_async_clear: data=%h valid=%b locked=%b ovf=%b drops=%0d expected all 0",
               out_data, out_valid, locked, overflow, drop_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    base = got.size();
    send_zeros(40);
    send_word(SYNC);
    send_word(32'h1234_ABCD);
    send_zeros(3);
    vectors++;
    if (got.size() - base !== 1 || got[got.size() - 1] !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL rmw_resume: got %0d words last=%h expected 1 word 1234abcd",
               got.size() - base, (got.size() > 0) ? got[got.size() - 1] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_frame_tracking();
    test_lock_loss();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
